// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall/flush requests from the stages, hold vector and redirect back.
// Latency: none (signal bundle only).
// Backpressure: none; the stall vector itself is the backpressure to the stages.
interface pipe_ctrl_if #(
    parameter int STAGES = 6,
    parameter int PC_W   = 32
);
    logic [STAGES-1:0] stall_req;
    logic              flush_req;
    logic [PC_W-1:0]   flush_pc;
    logic [STAGES-1:0] stall;
    logic              flush;
    logic [PC_W-1:0]   new_pc;
    logic [1:0]        state_o;

    // Pipeline side: raises requests, obeys hold/flush
    modport master (
        output stall_req, flush_req, flush_pc,
        input  stall, flush, new_pc, state_o
    );

    // Controller side
    modport slave (
        input  stall_req, flush_req, flush_pc,
        output stall, flush, new_pc, state_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller; optional stall watchdog under macro PIPE_CTRL_WDOG_EN.
// Latency: stall vector is combinational; flush/new_pc are registered, 1 cycle after flush_req.
// Backpressure: a stall request at stage k holds stages 0..k; flush overrides all stalls.
module pipe_ctrl #(
    parameter int STAGES     = 6,
    parameter int FLUSH_CYC  = 1,
    parameter int PC_W       = 32,
    parameter int WDOG_LIMIT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_WDOG_EN
    ,
    output logic        stall_timeout
`endif
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_flush;
    logic [PC_W-1:0]   r_new_pc;
    logic [CNT_W-1:0]  r_cnt;

    logic [STAGES-1:0] w_req_hi;
    logic              w_any_req;
    logic [STAGES-1:0] w_mask;
    logic              w_acc;

    // Bit 0 is the PC slot and never requests a stall on its own
    assign w_req_hi  = bus.stall_req & {{(STAGES-1){1'b1}}, 1'b0};
    assign w_any_req = |w_req_hi;

    // Prefix mask: every stage at or below the highest requester is held
    always_comb begin
        w_mask = '0;
        w_acc  = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_acc     = w_acc | w_req_hi[i];
            w_mask[i] = w_acc;
        end
    end

    // Reset and an active flush both release every hold immediately
    assign bus.stall   = (!resetn || r_state == FLUSH) ? '0 : w_mask;
    assign bus.flush   = r_flush;
    assign bus.new_pc  = r_new_pc;
    assign bus.state_o = r_state;

    // Controller FSM; flush_req wins from any state and restarts the window
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= RUN;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
            r_cnt    <= '0;
        end else if (bus.flush_req) begin
            r_state  <= FLUSH;
            r_flush  <= 1'b1;
            r_new_pc <= bus.flush_pc;
            r_cnt    <= CNT_W'(FLUSH_CYC - 1);
        end else begin
            case (r_state)
                RUN: begin
                    if (w_any_req) r_state <= STALL;
                end
                STALL: begin
                    if (!w_any_req) r_state <= RUN;
                end
                FLUSH: begin
                    if (r_cnt == '0) begin
                        r_flush <= 1'b0;
                        r_state <= w_any_req ? STALL : RUN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;
    logic            w_wd_hit;

    // Hit on the edge the counter lands on the limit, or while it sits there
    assign w_wd_hit = (r_state == STALL) &&
                      ((r_wd_cnt == WD_W'(WDOG_LIMIT - 1)) || (r_wd_cnt == WD_W'(WDOG_LIMIT)));
    assign stall_timeout = r_timeout;

    // Saturating stall-duration counter with sticky timeout flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == STALL) begin
                if (r_wd_cnt != WD_W'(WDOG_LIMIT)) r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
            if (bus.flush_req)  r_timeout <= 1'b0;
            else if (w_wd_hit)  r_timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (STAGES=6, FLUSH_CYC=3, PC_W=32, WDOG_LIMIT=4).
// Latency: expects flush one edge after flush_req, held FLUSH_CYC cycles.
// Backpressure: checks the combinational stall prefix and its suppression during flush.
module tb_pipe_ctrl;

    localparam int STAGES    = 6;
    localparam int FLUSH_CYC = 3;
    localparam int PC_W      = 32;
    localparam int WDOG_LIM  = 4;

    logic clk;
    logic resetn;
`ifdef PIPE_CTRL_WDOG_EN
    logic stall_timeout;
`endif

    pipe_ctrl_if #(.STAGES(STAGES), .PC_W(PC_W)) bus();

    pipe_ctrl #(
        .STAGES    (STAGES),
        .FLUSH_CYC (FLUSH_CYC),
        .PC_W      (PC_W),
        .WDOG_LIMIT(WDOG_LIM)
    ) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus)
`ifdef PIPE_CTRL_WDOG_EN
        ,
        .stall_timeout(stall_timeout)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    logic [PC_W-1:0] exp_pc_q[$];
    logic [PC_W-1:0] exp_pc;
    logic [PC_W-1:0] last_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Advance one edge, then settle 1 time unit away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        bus.stall_req = 6'b111110;
        bus.flush_req = 1'b0;
        bus.flush_pc  = '0;
        last_pc       = '0;
        repeat (2) @(posedge clk);
        #2;
        compared++; if (bus.stall !== 6'b000000) begin mismatched++; $display("FAIL reset_stall: got %b want %b", bus.stall, 6'b0); end
        compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        compared++; if (bus.new_pc !== 32'h0) begin mismatched++; $display("FAIL reset_new_pc: got %h want 0", bus.new_pc); end
        compared++; if (bus.state_o !== 2'd0) begin mismatched++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
        bus.stall_req = '0;
        #1;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_prefix();
        bus.stall_req = 6'b000100;
        #1;
        compared++; if (bus.stall !== 6'b000111) begin mismatched++; $display("FAIL prefix_000100: got %b want 000111", bus.stall); end
        bus.stall_req = 6'b001100;
        #1;
        compared++; if (bus.stall !== 6'b001111) begin mismatched++; $display("FAIL prefix_001100: got %b want 001111", bus.stall); end
        bus.stall_req = 6'b100010;
        #1;
        compared++; if (bus.stall !== 6'b111111) begin mismatched++; $display("FAIL prefix_100010: got %b want 111111", bus.stall); end
        bus.stall_req = 6'b000001;
        #1;
        compared++; if (bus.stall !== 6'b000000) begin mismatched++; $display("FAIL prefix_bit0: got %b want 000000", bus.stall); end
        tick();
        compared++; if (bus.state_o !== 2'd0) begin mismatched++; $display("FAIL bit0_no_stall_state: got %0d want 0", bus.state_o); end
        bus.stall_req = 6'b000010;
        tick();
        compared++; if (bus.state_o !== 2'd1) begin mismatched++; $display("FAIL run_to_stall: got %0d want 1", bus.state_o); end
        compared++; if (bus.stall !== 6'b000011) begin mismatched++; $display("FAIL stall_state_vec: got %b want 000011", bus.stall); end
        bus.stall_req = '0;
        tick();
        compared++; if (bus.state_o !== 2'd0) begin mismatched++; $display("FAIL stall_to_run: got %0d want 0", bus.state_o); end
    endtask

    task automatic test_flush_priority();
        int n;
        int guard;
        bus.stall_req = 6'b001000;
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'hBFC0_0380;
        exp_pc_q.push_back(32'hBFC0_0380);
        tick();
        bus.flush_req = 1'b0;
        exp_pc  = exp_pc_q.pop_front();
        last_pc = exp_pc;
        compared++; if (bus.new_pc !== exp_pc) begin mismatched++; $display("FAIL prio_new_pc: got %h want %h", bus.new_pc, exp_pc); end
        compared++; if (bus.state_o !== 2'd2) begin mismatched++; $display("FAIL prio_state: got %0d want 2", bus.state_o); end
        n = 0;
        guard = 0;
        while (bus.flush === 1'b1 && guard < 20) begin
            compared++; if (bus.stall !== 6'b000000) begin mismatched++; $display("FAIL prio_stall_in_flush: got %b want 000000", bus.stall); end
            n++;
            guard++;
            tick();
        end
        compared++; if (n !== FLUSH_CYC) begin mismatched++; $display("FAIL prio_flush_len: got %0d want %0d", n, FLUSH_CYC); end
        compared++; if (bus.state_o !== 2'd1) begin mismatched++; $display("FAIL prio_exit_state: got %0d want 1", bus.state_o); end
        compared++; if (bus.stall !== 6'b001111) begin mismatched++; $display("FAIL prio_exit_stall: got %b want 001111", bus.stall); end
        compared++; if (bus.new_pc !== last_pc) begin mismatched++; $display("FAIL prio_pc_hold: got %h want %h", bus.new_pc, last_pc); end
        bus.stall_req = '0;
        tick();
    endtask

    task automatic test_reflush();
        int n;
        int guard;
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h1234_5670;
        exp_pc_q.push_back(32'h1234_5670);
        tick();
        bus.flush_req = 1'b0;
        exp_pc = exp_pc_q.pop_front();
        compared++; if (bus.new_pc !== exp_pc) begin mismatched++; $display("FAIL reflush_first_pc: got %h want %h", bus.new_pc, exp_pc); end
        tick();
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h8000_0000;
        exp_pc_q.push_back(32'h8000_0000);
        tick();
        bus.flush_req = 1'b0;
        exp_pc  = exp_pc_q.pop_front();
        last_pc = exp_pc;
        compared++; if (bus.new_pc !== exp_pc) begin mismatched++; $display("FAIL reflush_second_pc: got %h want %h", bus.new_pc, exp_pc); end
        n = 0;
        guard = 0;
        while (bus.flush === 1'b1 && guard < 20) begin
            n++;
            guard++;
            tick();
        end
        compared++; if (n !== FLUSH_CYC) begin mismatched++; $display("FAIL reflush_len: got %0d want %0d", n, FLUSH_CYC); end
        compared++; if (bus.state_o !== 2'd0) begin mismatched++; $display("FAIL reflush_exit_state: got %0d want 0", bus.state_o); end
        compared++; if (bus.new_pc !== last_pc) begin mismatched++; $display("FAIL reflush_pc_hold: got %h want %h", bus.new_pc, last_pc); end
    endtask

    task automatic test_back_to_back();
        int n;
        int guard;
        for (int i = 0; i < 3; i++) begin
            bus.flush_req = 1'b1;
            bus.flush_pc  = 32'hA000_0000 + 32'(i * 16);
            exp_pc_q.push_back(32'hA000_0000 + 32'(i * 16));
            tick();
            exp_pc = exp_pc_q.pop_front();
            compared++; if (bus.new_pc !== exp_pc) begin mismatched++; $display("FAIL b2b_pc_%0d: got %h want %h", i, bus.new_pc, exp_pc); end
        end
        bus.flush_req = 1'b0;
        last_pc = exp_pc;
        // Three edges of flush already seen; newest request restarts the window
        n = 3;
        guard = 0;
        tick();
        while (bus.flush === 1'b1 && guard < 20) begin
            n++;
            guard++;
            tick();
        end
        compared++; if (n !== 3 + FLUSH_CYC - 1) begin mismatched++; $display("FAIL b2b_len: got %0d want %0d", n, 3 + FLUSH_CYC - 1); end
    endtask

    task automatic test_async_reset();
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'hDEAD_BEE0;
        exp_pc_q.push_back(32'hDEAD_BEE0);
        tick();
        bus.flush_req = 1'b0;
        exp_pc = exp_pc_q.pop_front();
        compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL areset_pre_flush: got %b want 1", bus.flush); end
        compared++; if (bus.new_pc !== exp_pc) begin mismatched++; $display("FAIL areset_pre_pc: got %h want %h", bus.new_pc, exp_pc); end
        bus.stall_req = 6'b010000;
        #2;
        resetn = 1'b0;
        #1;
        compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL areset_flush: got %b want 0", bus.flush); end
        compared++; if (bus.state_o !== 2'd0) begin mismatched++; $display("FAIL areset_state: got %0d want 0", bus.state_o); end
        compared++; if (bus.new_pc !== 32'h0) begin mismatched++; $display("FAIL areset_pc: got %h want 0", bus.new_pc); end
        compared++; if (bus.stall !== 6'b000000) begin mismatched++; $display("FAIL areset_stall: got %b want 000000", bus.stall); end
        tick();
        bus.stall_req = '0;
        resetn = 1'b1;
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h0000_4000;
        exp_pc_q.push_back(32'h0000_4000);
        tick();
        bus.flush_req = 1'b0;
        exp_pc = exp_pc_q.pop_front();
        compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL post_reset_flush: got %b want 1", bus.flush); end
        compared++; if (bus.new_pc !== exp_pc) begin mismatched++; $display("FAIL post_reset_pc: got %h want %h", bus.new_pc, exp_pc); end
        repeat (FLUSH_CYC + 1) tick();
        compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL post_reset_flush_end: got %b want 0", bus.flush); end
    endtask

`ifdef PIPE_CTRL_WDOG_EN
    task automatic test_wdog();
        compared++; if (stall_timeout !== 1'b0) begin mismatched++; $display("FAIL wdog_idle: got %b want 0", stall_timeout); end
        bus.stall_req = 6'b000010;
        repeat (WDOG_LIM + 3) tick();
        compared++; if (stall_timeout !== 1'b1) begin mismatched++; $display("FAIL wdog_set: got %b want 1", stall_timeout); end
        bus.stall_req = '0;
        repeat (2) tick();
        compared++; if (stall_timeout !== 1'b1) begin mismatched++; $display("FAIL wdog_sticky: got %b want 1", stall_timeout); end
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h0000_0100;
        tick();
        bus.flush_req = 1'b0;
        compared++; if (stall_timeout !== 1'b0) begin mismatched++; $display("FAIL wdog_clear: got %b want 0", stall_timeout); end
        repeat (FLUSH_CYC + 1) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_prefix();
        test_flush_priority();
        test_reflush();
        test_back_to_back();
        test_async_reset();
`ifdef PIPE_CTRL_WDOG_EN
        test_wdog();
`endif
        compared++; if (exp_pc_q.size() !== 0) begin mismatched++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_pc_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
